servo_lock_driver: RTL and testbench

SERVO_LOCK_DRIVER -- requirements
Module: servo_lock_driver

---
 rtl/servo_lock_driver.sv | 210 +++++++++++++++++++++
 tb/tb_servo_lock_driver.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/servo_lock_driver.sv
// servo_lock_driver
// Drives a hobby servo that actuates a lock. A fixed-length PWM frame is
// generated continuously. The pulse width ramps one step per frame toward
// the open or closed position. The open position is held for a limited number
// of frames before a forced relock. Every decision is taken on the frame
// boundary, so each emitted pulse is a whole, clean pulse.
module servo_lock_driver #(
  parameter int PERIOD_CLKS        = 1000000,
  parameter int PW_CLOSED_CLKS     = 50000,
  parameter int PW_OPEN_CLKS       = 100000,
  parameter int STEP_CLKS          = 1000,
  parameter int AUTO_RELOCK_FRAMES = 250
) (
  input  logic clk,
  input  logic rst,
  input  logic lock_open,
  output logic servo_pwm,
  output logic at_closed,
  output logic at_open,
  output logic moving,
  output logic relock_pulse
);

  // Counter width covers 0..PERIOD_CLKS-1. Every pulse width is below
  // PERIOD_CLKS, so the pulse width fits the same width.
  localparam int CW = (PERIOD_CLKS > 1) ? $clog2(PERIOD_CLKS) : 1;
  // The dwell width always has at least one bit, even when auto-relock is disabled.
  localparam int DW = $clog2(AUTO_RELOCK_FRAMES + 2);

  localparam logic [CW-1:0] CNT_LAST    = CW'(PERIOD_CLKS - 1);
  localparam logic [CW-1:0] PW_CLOSED   = CW'(PW_CLOSED_CLKS);
  localparam logic [CW-1:0] PW_OPEN     = CW'(PW_OPEN_CLKS);
  localparam int unsigned   STEP_U      = STEP_CLKS;
  localparam logic [DW-1:0] DWELL_LIMIT = DW'(AUTO_RELOCK_FRAMES);
  localparam logic [DW-1:0] DWELL_MAX   = {DW{1'b1}};
  localparam logic          RELOCK_EN   = (AUTO_RELOCK_FRAMES != 0);

  typedef enum logic [1:0] {
    ST_CLOSED  = 2'd0,
    ST_OPENING = 2'd1,
    ST_OPEN    = 2'd2,
    ST_CLOSING = 2'd3
  } state_t;

  // Move cur one step toward tgt and clamp at tgt. The step is never
  // added to or subtracted from cur unless the remaining gap is larger than
  // the step. This rules out overshoot and underflow.
  function automatic logic [CW-1:0] step_toward(input logic [CW-1:0] cur,
                                                input logic [CW-1:0] tgt);
    logic [CW-1:0] res;
    int unsigned   gap;
    res = cur;
    gap = 32'd0;
    if (cur < tgt) begin
      gap = 32'(tgt - cur);
      if (gap <= STEP_U) begin
        res = tgt;
      end else begin
        res = cur + CW'(STEP_CLKS);
      end
    end else if (cur > tgt) begin
      gap = 32'(cur - tgt);
      if (gap <= STEP_U) begin
        res = tgt;
      end else begin
        res = cur - CW'(STEP_CLKS);
      end
    end else begin
      res = cur;
    end
    return res;
  endfunction

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_pw;
  state_t        r_state;
  logic [DW-1:0] r_dwell;
  logic          r_timed_out;
  logic          r_servo_pwm;
  logic          r_relock_pulse;
  logic          r_at_closed;
  logic          r_at_open;
  logic          r_moving;

  logic          w_boundary;
  logic          w_target_open;
  logic [CW-1:0] w_target;
  logic [CW-1:0] w_pw_next;
  state_t        w_state_next;
  logic [DW-1:0] w_dwell_inc;
  logic          w_relock_fire;

  // Next-frame decisions: target, stepped pulse width, FSM successor, relock trigger
  always_comb begin
    w_boundary    = (r_cnt == CNT_LAST);
    w_target_open = lock_open & ~r_timed_out;
    if (w_target_open) begin
      w_target = PW_OPEN;
    end else begin
      w_target = PW_CLOSED;
    end
    w_pw_next = step_toward(r_pw, w_target);

    w_state_next = r_state;
    case (r_state)
      ST_CLOSED: begin
        if (w_target_open) begin
          w_state_next = ST_OPENING;
        end else begin
          w_state_next = ST_CLOSED;
        end
      end
      ST_OPENING: begin
        if (!w_target_open) begin
          w_state_next = ST_CLOSING;
        end else if (w_pw_next == PW_OPEN) begin
          w_state_next = ST_OPEN;
        end else begin
          w_state_next = ST_OPENING;
        end
      end
      ST_OPEN: begin
        if (!w_target_open) begin
          w_state_next = ST_CLOSING;
        end else begin
          w_state_next = ST_OPEN;
        end
      end
      ST_CLOSING: begin
        if (w_target_open) begin
          w_state_next = ST_OPENING;
        end else if (w_pw_next == PW_CLOSED) begin
          w_state_next = ST_CLOSED;
        end else begin
          w_state_next = ST_CLOSING;
        end
      end
      default: begin
        w_state_next = ST_CLOSED;
      end
    endcase

    // Saturate so that the counter never wraps when auto-relock is disabled
    if (r_dwell == DWELL_MAX) begin
      w_dwell_inc = r_dwell;
    end else begin
      w_dwell_inc = r_dwell + DW'(1);
    end

    // Relock only fires on a boundary where the lock stays open
    w_relock_fire = w_boundary & RELOCK_EN & (r_state == ST_OPEN) &
                    w_target_open & (w_dwell_inc == DWELL_LIMIT);
  end

  // Frame counter, PWM, FSM, dwell/timeout tracking and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt          <= '0;
      r_pw           <= PW_CLOSED;
      r_state        <= ST_CLOSED;
      r_dwell        <= '0;
      r_timed_out    <= 1'b0;
      r_servo_pwm    <= 1'b0;
      r_relock_pulse <= 1'b0;
      r_at_closed    <= 1'b1;
      r_at_open      <= 1'b0;
      r_moving       <= 1'b0;
    end else begin
      if (w_boundary) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
      r_servo_pwm    <= (r_cnt < r_pw);
      r_relock_pulse <= w_relock_fire;

      if (w_boundary) begin
        r_pw        <= w_pw_next;
        r_state     <= w_state_next;
        r_at_closed <= (w_state_next == ST_CLOSED);
        r_at_open   <= (w_state_next == ST_OPEN);
        r_moving    <= (w_state_next == ST_OPENING) || (w_state_next == ST_CLOSING);

        if ((w_state_next == ST_OPEN) && (r_state != ST_OPEN)) begin
          r_dwell <= '0;
        end else if (r_state == ST_OPEN) begin
          r_dwell <= w_dwell_inc;
        end else begin
          r_dwell <= r_dwell;
        end

        // The timeout is latched until a boundary sees the open request withdrawn
        if (!lock_open) begin
          r_timed_out <= 1'b0;
        end else if (w_relock_fire) begin
          r_timed_out <= 1'b1;
        end else begin
          r_timed_out <= r_timed_out;
        end
      end
    end
  end

  assign servo_pwm    = r_servo_pwm;
  assign relock_pulse = r_relock_pulse;
  assign at_closed    = r_at_closed;
  assign at_open      = r_at_open;
  assign moving       = r_moving;

endmodule

// File: tb/tb_servo_lock_driver.sv
// Directed testbench for servo_lock_driver. The small frame (100 clocks)
// makes pulse widths directly countable. A second instance, with
// auto-relock disabled, runs alongside to show that it holds open.
module tb_servo_lock_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, lock_open;
  logic servo_pwm, at_closed, at_open, moving, relock_pulse;
  logic rst0, lock_open0;
  logic servo_pwm0, at_closed0, at_open0, moving0, relock_pulse0;

  int checks = 0;
  int errors = 0;
  int relock_cnt0 = 0;
  int open_cycles0 = 0;
  int h, r;

  servo_lock_driver #(
    .PERIOD_CLKS(100), .PW_CLOSED_CLKS(10), .PW_OPEN_CLKS(30),
    .STEP_CLKS(5), .AUTO_RELOCK_FRAMES(3)
  ) dut (
    .clk(clk), .rst(rst), .lock_open(lock_open), .servo_pwm(servo_pwm),
    .at_closed(at_closed), .at_open(at_open), .moving(moving),
    .relock_pulse(relock_pulse)
  );

  servo_lock_driver #(
    .PERIOD_CLKS(100), .PW_CLOSED_CLKS(10), .PW_OPEN_CLKS(30),
    .STEP_CLKS(5), .AUTO_RELOCK_FRAMES(0)
  ) dut0 (
    .clk(clk), .rst(rst0), .lock_open(lock_open0), .servo_pwm(servo_pwm0),
    .at_closed(at_closed0), .at_open(at_open0), .moving(moving0),
    .relock_pulse(relock_pulse0)
  );

  // Observe the no-relock instance on every cycle
  always @(negedge clk) begin
    if (relock_pulse0) relock_cnt0++;
    if (at_open0) open_cycles0++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic status(input string tag, input int c, input int o, input int m);
    check({tag, "_at_closed"}, int'(at_closed), c);
    check({tag, "_at_open"}, int'(at_open), o);
    check({tag, "_moving"}, int'(moving), m);
  endtask

  // One whole frame: count high PWM cycles and relock pulses; optionally
  // change lock_open at cycle chg_at within the frame
  task automatic frame(input int chg_at, input logic chg_val,
                       output int highs, output int relocks);
    highs = 0;
    relocks = 0;
    for (int i = 0; i < 100; i++) begin
      if (i == chg_at) lock_open = chg_val;
      tick(1);
      highs += int'(servo_pwm);
      relocks += int'(relock_pulse);
    end
  endtask

  initial begin
    rst = 1'b1; lock_open = 1'b0; rst0 = 1'b1; lock_open0 = 1'b1;
    tick(3);
    check("rst_pwm", int'(servo_pwm), 0);
    check("rst_relock", int'(relock_pulse), 0);
    status("rst", 1, 0, 0);
    rst = 1'b0; rst0 = 1'b0;

    // Closed idle: 10-cycle pulses
    for (int f = 0; f < 5; f++) begin
      frame(-1, 1'b0, h, r);
      check("idle_pw", h, 10);
      status("idle", 1, 0, 0);
    end

    // Open request mid-frame, ramp 15,20,25,30
    frame(50, 1'b1, h, r);
    check("open_req_frame_pw", h, 10);
    status("ramp_b1", 0, 0, 1);
    frame(-1, 1'b1, h, r);
    check("ramp_pw15", h, 15);
    status("ramp_b2", 0, 0, 1);
    frame(-1, 1'b1, h, r);
    check("ramp_pw20", h, 20);
    status("ramp_b3", 0, 0, 1);
    frame(-1, 1'b1, h, r);
    check("ramp_pw25", h, 25);
    status("ramp_b4", 0, 1, 0);

    // Dwell in OPEN, auto-relock after three boundaries
    frame(-1, 1'b1, h, r);
    check("dwell1_pw", h, 30);
    check("dwell1_relock", r, 0);
    frame(-1, 1'b1, h, r);
    check("dwell2_pw", h, 30);
    check("dwell2_relock", r, 0);
    frame(-1, 1'b1, h, r);
    check("dwell3_pw", h, 30);
    check("dwell3_relock_cnt", r, 1);
    check("relock_now", int'(relock_pulse), 1);
    status("relock", 0, 1, 0);
    frame(-1, 1'b1, h, r);
    check("post_relock_pw", h, 30);
    check("post_relock_cnt", r, 0);
    status("relock_close_b1", 0, 0, 1);
    frame(-1, 1'b1, h, r);
    check("relock_pw25", h, 25);
    frame(-1, 1'b1, h, r);
    check("relock_pw20", h, 20);
    status("relock_close_b3", 0, 0, 1);
    frame(-1, 1'b1, h, r);
    check("relock_pw15", h, 15);
    status("relock_closed", 1, 0, 0);
    frame(-1, 1'b1, h, r);
    check("timed_out_hold_pw", h, 10);
    status("timed_out_hold", 1, 0, 0);
    frame(10, 1'b0, h, r);
    check("clear_timeout_pw", h, 10);
    status("clear_timeout", 1, 0, 0);
    frame(10, 1'b1, h, r);
    check("reopen_req_pw", h, 10);
    status("reopen", 0, 0, 1);

    // Reversal during OPENING at pw=20
    frame(-1, 1'b1, h, r);
    check("rev_pw15", h, 15);
    frame(50, 1'b0, h, r);
    check("rev_pw20", h, 20);
    status("rev_closing", 0, 0, 1);
    frame(-1, 1'b0, h, r);
    check("rev_pw15_down", h, 15);
    status("rev_closed", 1, 0, 0);
    frame(-1, 1'b0, h, r);
    check("rev_idle_pw", h, 10);

    // Reset in the middle of a pw=25 OPENING frame
    frame(10, 1'b1, h, r);
    check("rst_ramp_pw10", h, 10);
    frame(-1, 1'b1, h, r);
    check("rst_ramp_pw15", h, 15);
    frame(-1, 1'b1, h, r);
    check("rst_ramp_pw20", h, 20);
    status("rst_ramp", 0, 0, 1);
    tick(5);
    check("pre_rst_pwm", int'(servo_pwm), 1);
    rst = 1'b1; lock_open = 1'b0;
    tick(1);
    check("midrst_pwm", int'(servo_pwm), 0);
    status("midrst", 1, 0, 0);
    rst = 1'b0;
    frame(-1, 1'b0, h, r);
    check("after_rst_pw_a", h, 10);
    status("after_rst", 1, 0, 0);
    frame(-1, 1'b0, h, r);
    check("after_rst_pw_b", h, 10);

    // Let the no-relock instance accumulate more open time
    for (int f = 0; f < 3; f++) frame(-1, 1'b0, h, r);
    check("norelock_at_open", int'(at_open0), 1);
    check("norelock_pulses", relock_cnt0, 0);
    check("norelock_open_time", int'(open_cycles0 >= 2000), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
